// File: rtl/bsg_manycore_remote_mem_responder.sv
// ---------------------------------------------------------------------------
// bsg_manycore_remote_mem_responder
//
// Target-side responder for remote load/store requests arriving from a
// manycore endpoint. Requests are serviced against a local word-addressed
// memory. Each accepted request produces exactly one return: load data or a
// store ack. The return carries the requester's load id and coordinates.
//
// Pipeline:
//   stage 0 : accept, write memory (stores) or start synchronous read (loads)
//   stage 1 : response registered, pushed into the return FIFO
//   FIFO    : head drives ret_*, popped on ret_v_o & ret_ready_i
//
// Ports:
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   in_v_i / in_yumi_o        request valid / accepted this cycle
//                             (in_yumi_o is combinational, incl. ret_ready_i)
//   in_we_i, in_addr_i,
//   in_data_i, in_mask_i      store/load, word address, store data, byte mask
//   in_load_id_i,
//   in_src_x_i, in_src_y_i    requester tag echoed in the return
//   ret_v_o / ret_ready_i     return valid / consumer ready
//   ret_is_load_o, ret_data_o,
//   ret_load_id_o, ret_x_o,
//   ret_y_o                   return payload (zero while ret_v_o = 0)
//   err_o                     sticky out-of-range flag, cleared only by reset
//
// Configuration macro:
//   BSG_MANYCORE_RESPONDER_BYTE_MASK_EN  when defined, stores write only the
//   bytes selected by in_mask_i; otherwise in_mask_i is ignored and stores
//   write the full word.
// ---------------------------------------------------------------------------
module bsg_manycore_remote_mem_responder #(
  parameter int unsigned data_width_p    = 32,
  parameter int unsigned addr_width_p    = 32,
  parameter int unsigned x_cord_width_p  = 4,
  parameter int unsigned y_cord_width_p  = 4,
  parameter int unsigned load_id_width_p = 11,
  parameter int unsigned mem_els_p       = 1024,
  parameter int unsigned ret_fifo_els_p  = 2
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,

  input  logic                         in_v_i,
  output logic                         in_yumi_o,
  input  logic                         in_we_i,
  input  logic [addr_width_p-1:0]      in_addr_i,
  input  logic [data_width_p-1:0]      in_data_i,
  input  logic [data_width_p/8-1:0]    in_mask_i,
  input  logic [load_id_width_p-1:0]   in_load_id_i,
  input  logic [x_cord_width_p-1:0]    in_src_x_i,
  input  logic [y_cord_width_p-1:0]    in_src_y_i,

  output logic                         ret_v_o,
  input  logic                         ret_ready_i,
  output logic                         ret_is_load_o,
  output logic [data_width_p-1:0]      ret_data_o,
  output logic [load_id_width_p-1:0]   ret_load_id_o,
  output logic [x_cord_width_p-1:0]    ret_x_o,
  output logic [y_cord_width_p-1:0]    ret_y_o,

  output logic                         err_o
);

  localparam int unsigned mem_addr_width_lp = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;
  localparam int unsigned ptr_width_lp      = $clog2(ret_fifo_els_p);
  localparam int unsigned cnt_width_lp      = $clog2(ret_fifo_els_p + 1);
  localparam int unsigned occ_width_lp      = cnt_width_lp + 1;

  typedef struct packed {
    logic                       is_load;
    logic [data_width_p-1:0]    data;
    logic [load_id_width_p-1:0] load_id;
    logic [x_cord_width_p-1:0]  x;
    logic [y_cord_width_p-1:0]  y;
  } ret_pkt_s;

  // Storage (not reset; contents survive reset)
  logic [data_width_p-1:0]    mem_r      [mem_els_p];
  ret_pkt_s                   fifo_mem_r [ret_fifo_els_p];

  // Stage 1 registers
  logic                       s1_v_r;
  logic                       s1_we_r;
  logic                       s1_oor_r;
  logic [load_id_width_p-1:0] s1_load_id_r;
  logic [x_cord_width_p-1:0]  s1_x_r;
  logic [y_cord_width_p-1:0]  s1_y_r;
  logic [data_width_p-1:0]    s1_rdata_r;

  // Return FIFO control
  logic [ptr_width_lp-1:0]    wr_ptr_r;
  logic [ptr_width_lp-1:0]    rd_ptr_r;
  logic [cnt_width_lp-1:0]    count_r;

  logic                       err_r;
  logic                       in_range;
  logic                       deq;
  logic [mem_addr_width_lp-1:0] mem_idx;
  ret_pkt_s                   s1_pkt;
  ret_pkt_s                   head_pkt;

  // Range check on the full request address width
  assign in_range = ({1'b0, in_addr_i} < (addr_width_p+1)'(mem_els_p));
  assign mem_idx  = in_addr_i[mem_addr_width_lp-1:0];

  assign ret_v_o  = (count_r != '0);
  assign deq      = ret_v_o & ret_ready_i;

  // Accept only while the stage-1 slot plus FIFO occupancy, net of this
  // cycle's pop, leaves room; this guarantees stage 1 can always push.
  assign in_yumi_o = in_v_i
                   & ((occ_width_lp'(count_r) + occ_width_lp'(s1_v_r))
                      < (occ_width_lp'(ret_fifo_els_p) + occ_width_lp'(deq)));

  // Memory write port
  always_ff @(posedge clk_i) begin : mem_write
    if (in_yumi_o & in_we_i & in_range) begin
`ifdef BSG_MANYCORE_RESPONDER_BYTE_MASK_EN
      for (int b = 0; b < int'(data_width_p/8); b++) begin
        if (in_mask_i[b]) begin
          mem_r[mem_idx][8*b +: 8] <= in_data_i[8*b +: 8];
        end
      end
`else
      mem_r[mem_idx] <= in_data_i;
`endif
    end
  end

`ifndef BSG_MANYCORE_RESPONDER_BYTE_MASK_EN
  logic unused_mask;
  assign unused_mask = ^in_mask_i;
`endif

  // Synchronous read port; a load right after a store to the same word sees
  // the new value because the write lands at the earlier edge.
  always_ff @(posedge clk_i) begin : mem_read
    if (in_yumi_o & ~in_we_i & in_range) begin
      s1_rdata_r <= mem_r[mem_idx];
    end
  end

  // Stage 1 capture of request tag and status
  always_ff @(posedge clk_i or negedge reset_n_i) begin : stage1
    if (!reset_n_i) begin
      s1_v_r       <= 1'b0;
      s1_we_r      <= 1'b0;
      s1_oor_r     <= 1'b0;
      s1_load_id_r <= '0;
      s1_x_r       <= '0;
      s1_y_r       <= '0;
    end else begin
      s1_v_r <= in_yumi_o;
      if (in_yumi_o) begin
        s1_we_r      <= in_we_i;
        s1_oor_r     <= ~in_range;
        s1_load_id_r <= in_load_id_i;
        s1_x_r       <= in_src_x_i;
        s1_y_r       <= in_src_y_i;
      end
    end
  end

  // Stores and out-of-range loads return zero data
  always_comb begin
    s1_pkt         = '0;
    s1_pkt.is_load = ~s1_we_r;
    s1_pkt.data    = (s1_we_r | s1_oor_r) ? '0 : s1_rdata_r;
    s1_pkt.load_id = s1_load_id_r;
    s1_pkt.x       = s1_x_r;
    s1_pkt.y       = s1_y_r;
  end

  // Return FIFO storage
  always_ff @(posedge clk_i) begin : fifo_write
    if (s1_v_r) begin
      fifo_mem_r[wr_ptr_r] <= s1_pkt;
    end
  end

  // Return FIFO pointers and occupancy
  always_ff @(posedge clk_i or negedge reset_n_i) begin : fifo_ctrl
    if (!reset_n_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (s1_v_r) begin
        wr_ptr_r <= (wr_ptr_r == ptr_width_lp'(ret_fifo_els_p - 1))
                    ? '0 : wr_ptr_r + ptr_width_lp'(1);
      end
      if (deq) begin
        rd_ptr_r <= (rd_ptr_r == ptr_width_lp'(ret_fifo_els_p - 1))
                    ? '0 : rd_ptr_r + ptr_width_lp'(1);
      end
      case ({s1_v_r, deq})
        2'b10:   count_r <= count_r + cnt_width_lp'(1);
        2'b01:   count_r <= count_r - cnt_width_lp'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky out-of-range flag
  always_ff @(posedge clk_i or negedge reset_n_i) begin : err_flag
    if (!reset_n_i) begin
      err_r <= 1'b0;
    end else if (in_yumi_o & ~in_range) begin
      err_r <= 1'b1;
    end
  end

  assign err_o = err_r;

  // Head of FIFO, forced to zero when empty so stale entries never show
  assign head_pkt      = fifo_mem_r[rd_ptr_r];
  assign ret_is_load_o = ret_v_o ? head_pkt.is_load : 1'b0;
  assign ret_data_o    = ret_v_o ? head_pkt.data    : '0;
  assign ret_load_id_o = ret_v_o ? head_pkt.load_id : '0;
  assign ret_x_o       = ret_v_o ? head_pkt.x       : '0;
  assign ret_y_o       = ret_v_o ? head_pkt.y       : '0;

endmodule

// File: tb/tb_bsg_manycore_remote_mem_responder.sv
// ---------------------------------------------------------------------------
// Testbench for bsg_manycore_remote_mem_responder.
// Directed table, hand sequences for backpressure and mid-stream reset, and
// a randomized phase checked against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_bsg_manycore_remote_mem_responder;

  localparam int unsigned DW = 32, AW = 32, XW = 4, YW = 4, IDW = 11;
  localparam int unsigned MEM_ELS = 1024, FIFO_ELS = 2;

`ifdef BSG_MANYCORE_RESPONDER_BYTE_MASK_EN
  localparam logic [31:0] MASKED_EXP = 32'h11BB33DD;
`else
  localparam logic [31:0] MASKED_EXP = 32'hAABBCCDD;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_n;
  logic           in_v, in_yumi, in_we;
  logic [AW-1:0]  in_addr;
  logic [DW-1:0]  in_data;
  logic [3:0]     in_mask;
  logic [IDW-1:0] in_load_id;
  logic [XW-1:0]  in_src_x;
  logic [YW-1:0]  in_src_y;
  logic           ret_v, ret_ready, ret_is_load, err;
  logic [DW-1:0]  ret_data;
  logic [IDW-1:0] ret_load_id;
  logic [XW-1:0]  ret_x;
  logic [YW-1:0]  ret_y;

  bsg_manycore_remote_mem_responder #(
    .data_width_p(DW), .addr_width_p(AW), .x_cord_width_p(XW),
    .y_cord_width_p(YW), .load_id_width_p(IDW), .mem_els_p(MEM_ELS),
    .ret_fifo_els_p(FIFO_ELS)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .in_v_i(in_v), .in_yumi_o(in_yumi), .in_we_i(in_we), .in_addr_i(in_addr),
    .in_data_i(in_data), .in_mask_i(in_mask), .in_load_id_i(in_load_id),
    .in_src_x_i(in_src_x), .in_src_y_i(in_src_y),
    .ret_v_o(ret_v), .ret_ready_i(ret_ready), .ret_is_load_o(ret_is_load),
    .ret_data_o(ret_data), .ret_load_id_o(ret_load_id), .ret_x_o(ret_x),
    .ret_y_o(ret_y), .err_o(err)
  );

  // Expected return, tagged with the cycle it was accepted in
  typedef struct {
    bit             is_load;
    logic [31:0]    data;
    bit             known;
    logic [IDW-1:0] id;
    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    int             acc;
  } resp_t;

  typedef struct {
    bit             we;
    logic [31:0]    addr;
    logic [31:0]    data;
    logic [3:0]     mask;
    logic [IDW-1:0] id;
    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    bit             exp_is_load;
    logic [31:0]    exp_data;
    bit             exp_err;
  } vec_t;

  resp_t          exp_q[$];
  logic [31:0]    mdl [int];
  bit             mdl_err;
  int             cyc;
  int             n_checks, n_fail;
  int             n_rets;
  bit             last_acc, got_ret;
  logic [IDW-1:0] ret_ids[$];
  bit             last_is_load;
  logic [31:0]    last_data;
  logic [IDW-1:0] last_id;
  logic [XW-1:0]  last_x;
  logic [YW-1:0]  last_y;
  bit             hold_prev;
  bit             prev_is_load;
  logic [31:0]    prev_data;
  logic [IDW-1:0] prev_id;
  logic [XW-1:0]  prev_x;
  logic [YW-1:0]  prev_y;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Reference model: one return per accepted request, in acceptance order
  task automatic model_accept();
    resp_t r;
    int    a;
    r.is_load = !in_we;
    r.data    = 32'h0;
    r.known   = 1'b1;
    r.id      = in_load_id;
    r.x       = in_src_x;
    r.y       = in_src_y;
    r.acc     = cyc;
    if (in_addr >= MEM_ELS) begin
      mdl_err = 1'b1;
    end else if (in_we) begin
      a = int'(in_addr);
`ifdef BSG_MANYCORE_RESPONDER_BYTE_MASK_EN
      if (mdl.exists(a)) mdl[a] = merge(mdl[a], in_data, in_mask);
      else if (in_mask == 4'hF) mdl[a] = in_data;
`else
      mdl[a] = in_data;
`endif
    end else begin
      a = int'(in_addr);
      if (mdl.exists(a)) r.data = mdl[a];
      else r.known = 1'b0;
    end
    exp_q.push_back(r);
  endtask

  // One clock cycle: check outputs at the falling edge, then advance
  task automatic step();
    resp_t h;
    bit    exp_rv, exp_deq, exp_yumi;
    @(negedge clk);
    exp_rv   = (exp_q.size() > 0) && (cyc - exp_q[0].acc >= 2);
    exp_deq  = exp_rv && ret_ready;
    exp_yumi = in_v && ((exp_q.size() - int'(exp_deq)) < int'(FIFO_ELS));
    chk("ret_v", 64'(ret_v), 64'(exp_rv));
    chk("err", 64'(err), 64'(mdl_err));
    chk("in_yumi", 64'(in_yumi), 64'(exp_yumi));
    if (hold_prev && ret_v) begin
      chk("hold_is_load", 64'(ret_is_load), 64'(prev_is_load));
      chk("hold_data", 64'(ret_data), 64'(prev_data));
      chk("hold_id", 64'(ret_load_id), 64'(prev_id));
      chk("hold_xy", 64'({ret_x, ret_y}), 64'({prev_x, prev_y}));
    end
    hold_prev    = ret_v && !ret_ready;
    prev_is_load = ret_is_load;
    prev_data    = ret_data;
    prev_id      = ret_load_id;
    prev_x       = ret_x;
    prev_y       = ret_y;
    got_ret = 1'b0;
    if (ret_v && ret_ready) begin
      got_ret      = 1'b1;
      n_rets++;
      last_is_load = ret_is_load;
      last_data    = ret_data;
      last_id      = ret_load_id;
      last_x       = ret_x;
      last_y       = ret_y;
      ret_ids.push_back(ret_load_id);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_return: got id 0x%0h expected no return (cycle %0d)",
                 ret_load_id, cyc);
      end else begin
        h = exp_q.pop_front();
        chk("ret_is_load", 64'(ret_is_load), 64'(h.is_load));
        chk("ret_id", 64'(ret_load_id), 64'(h.id));
        chk("ret_x", 64'(ret_x), 64'(h.x));
        chk("ret_y", 64'(ret_y), 64'(h.y));
        if (h.known) chk("ret_data", 64'(ret_data), 64'(h.data));
      end
    end
    last_acc = in_yumi;
    if (in_yumi) model_accept();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_req(input bit we, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] mask, input logic [IDW-1:0] id,
                         input logic [XW-1:0] x, input logic [YW-1:0] y);
    in_v = 1'b1; in_we = we; in_addr = addr; in_data = data; in_mask = mask;
    in_load_id = id; in_src_x = x; in_src_y = y;
  endtask

  task automatic drain();
    in_v = 1'b0;
    ret_ready = 1'b1;
    for (int k = 0; k < 50 && exp_q.size() > 0; k++) step();
    step();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  vec_t tbl [13];

  initial begin : watchdog
    #2000000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int acc_n, base;
    bit ok;
    logic [31:0] last_st;

    //        we    addr          data          mask  id      x     y     isld  exp_data       err
    tbl[0]  = '{1'b1, 32'd0,    32'h0BADF00D, 4'hF, 11'd1,  4'd1, 4'd1, 1'b0, 32'h0,         1'b0};
    tbl[1]  = '{1'b1, 32'd7,    32'h77777777, 4'hF, 11'd2,  4'd3, 4'd2, 1'b0, 32'h0,         1'b0};
    tbl[2]  = '{1'b1, 32'd5,    32'hDEADBEEF, 4'hF, 11'd3,  4'd2, 4'd1, 1'b0, 32'h0,         1'b0};
    tbl[3]  = '{1'b0, 32'd5,    32'h0,        4'hF, 11'd4,  4'd2, 4'd1, 1'b1, 32'hDEADBEEF,  1'b0};
    tbl[4]  = '{1'b0, 32'd1024, 32'h0,        4'hF, 11'd5,  4'd5, 4'd6, 1'b1, 32'h0,         1'b1};
    tbl[5]  = '{1'b1, 32'd1031, 32'h12345678, 4'hF, 11'd6,  4'd7, 4'd8, 1'b0, 32'h0,         1'b1};
    tbl[6]  = '{1'b0, 32'd7,    32'h0,        4'hF, 11'd7,  4'd1, 4'd2, 1'b1, 32'h77777777,  1'b1};
    tbl[7]  = '{1'b0, 32'd0,    32'h0,        4'hF, 11'd8,  4'd0, 4'd0, 1'b1, 32'h0BADF00D,  1'b1};
    tbl[8]  = '{1'b1, 32'd9,    32'h11223344, 4'hF, 11'd9,  4'd4, 4'd4, 1'b0, 32'h0,         1'b1};
    tbl[9]  = '{1'b1, 32'd9,    32'hAABBCCDD, 4'h5, 11'd10, 4'd4, 4'd4, 1'b0, 32'h0,         1'b1};
    tbl[10] = '{1'b0, 32'd9,    32'h0,        4'hF, 11'd11, 4'd4, 4'd4, 1'b1, MASKED_EXP,    1'b1};
    tbl[11] = '{1'b1, 32'd1023, 32'hCAFEF00D, 4'hF, 11'd12, 4'hF, 4'hF, 1'b0, 32'h0,         1'b1};
    tbl[12] = '{1'b0, 32'd1023, 32'h0,        4'hF, 11'd13, 4'hE, 4'hD, 1'b1, 32'hCAFEF00D,  1'b1};

    n_checks = 0; n_fail = 0; cyc = 0; n_rets = 0; mdl_err = 1'b0; hold_prev = 1'b0;
    reset_n = 1'b0; ret_ready = 1'b1;
    in_v = 1'b0; in_we = 1'b0; in_addr = '0; in_data = '0; in_mask = '0;
    in_load_id = '0; in_src_x = '0; in_src_y = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ret_v", 64'(ret_v), 64'd0);
    chk("rst_in_yumi", 64'(in_yumi), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_ret_fields", 64'({ret_is_load, ret_load_id, ret_x, ret_y}), 64'd0);
    chk("rst_ret_data", 64'(ret_data), 64'd0);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table: one request at a time, latency and fields checked
    for (int i = 0; i < 13; i++) begin
      set_req(tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].mask, tbl[i].id, tbl[i].x, tbl[i].y);
      step();
      chk("tbl_accept", 64'(last_acc), 64'd1);
      in_v = 1'b0;
      chk("tbl_err_after_accept", 64'(err), 64'(tbl[i].exp_err));
      ok = 1'b0;
      for (int k = 0; k < 8 && !ok; k++) begin
        step();
        if (got_ret) ok = 1'b1;
      end
      chk("tbl_return_arrived", 64'(ok), 64'd1);
      if (ok) begin
        chk("tbl_is_load", 64'(last_is_load), 64'(tbl[i].exp_is_load));
        chk("tbl_data", 64'(last_data), 64'(tbl[i].exp_data));
        chk("tbl_id", 64'(last_id), 64'(tbl[i].id));
        chk("tbl_xy", 64'({last_x, last_y}), 64'({tbl[i].x, tbl[i].y}));
      end
    end
    drain();

    // Backpressure: only FIFO_ELS loads accepted while ready is low
    ret_ready = 1'b0;
    ret_ids.delete();
    acc_n = 0;
    for (int c = 0; c < 6; c++) begin
      set_req(1'b0, 32'd5, 32'h0, 4'hF, IDW'(20 + acc_n), 4'd3, 4'd3);
      step();
      if (last_acc) acc_n++;
    end
    chk("bp_accepted", 64'(acc_n), 64'(FIFO_ELS));
    chk("bp_yumi_low", 64'(in_yumi), 64'd0);
    ret_ready = 1'b1;
    for (int c = 0; c < 20 && acc_n < 4; c++) begin
      in_load_id = IDW'(20 + acc_n);
      step();
      if (last_acc) acc_n++;
    end
    chk("bp_all_accepted", 64'(acc_n), 64'd4);
    drain();
    chk("bp_ret_count", 64'(ret_ids.size()), 64'd4);
    for (int k = 0; k < 4 && k < ret_ids.size(); k++)
      chk("bp_ret_order", 64'(ret_ids[k]), 64'(20 + k));

    // Streaming: alternating store / load, one accept per cycle
    ret_ready = 1'b1;
    base = n_rets;
    last_st = 32'd16;
    for (int i = 0; i < 64; i++) begin
      if (i % 2 == 0) begin
        last_st = 32'($urandom_range(16, 31));
        set_req(1'b1, last_st, $urandom, 4'hF, IDW'($urandom), XW'($urandom), YW'($urandom));
      end else begin
        set_req(1'b0, last_st, 32'h0, 4'hF, IDW'($urandom), XW'($urandom), YW'($urandom));
      end
      step();
      chk("stream_yumi", 64'(last_acc), 64'd1);
    end
    drain();
    chk("stream_ret_count", 64'(n_rets - base), 64'd64);

    // Randomized traffic with random backpressure, including out-of-range
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      logic [31:0] a;
      r = $urandom_range(0, 19);
      if (r == 0) a = 32'(MEM_ELS + $urandom_range(0, 7));
      else if (r == 1) a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else a = 32'($urandom_range(0, 31));
      set_req(1'($urandom), a, $urandom, 4'($urandom), IDW'($urandom),
              XW'($urandom), YW'($urandom));
      in_v = ($urandom_range(0, 3) != 0);
      ret_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    // Mid-stream reset with two returns pending
    mdl[5] = 32'h5A5A_0005;
    set_req(1'b1, 32'd5, 32'h5A5A_0005, 4'hF, 11'd30, 4'd1, 4'd1);
    step();
    chk("rs_store_accept", 64'(last_acc), 64'd1);
    in_v = 1'b0;
    drain();
    ret_ready = 1'b0;
    acc_n = 0;
    for (int c = 0; c < 10 && acc_n < 2; c++) begin
      set_req(1'b0, 32'd5, 32'h0, 4'hF, IDW'(40 + acc_n), 4'd2, 4'd2);
      step();
      if (last_acc) acc_n++;
    end
    in_v = 1'b0;
    step();
    step();
    chk("rs_pending_ret_v", 64'(ret_v), 64'd1);
    chk("rs_pending_err", 64'(err), 64'(mdl_err));
    #2 reset_n = 1'b0;
    #1;
    chk("rs_ret_v_now", 64'(ret_v), 64'd0);
    chk("rs_err_now", 64'(err), 64'd0);
    chk("rs_ret_fields_now", 64'({ret_is_load, ret_load_id, ret_x, ret_y}), 64'd0);
    chk("rs_ret_data_now", 64'(ret_data), 64'd0);
    exp_q.delete();
    mdl_err = 1'b0;
    hold_prev = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    ret_ready = 1'b1;
    set_req(1'b0, 32'd5, 32'h0, 4'hF, 11'd50, 4'd6, 4'd7);
    step();
    chk("rs_load_accept", 64'(last_acc), 64'd1);
    in_v = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 8 && !ok; k++) begin
      step();
      if (got_ret) ok = 1'b1;
    end
    chk("rs_load_returned", 64'(ok), 64'd1);
    if (ok) chk("rs_load_data", 64'(last_data), 64'h5A5A_0005);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bsg_manycore_remote_mem_responder.md
# bsg_manycore_remote_mem_responder

Target-side counterpart to the gather/scatter DMA initiator. Services decoded remote load/store requests from a manycore endpoint against a local word-addressed memory and returns load data or store acknowledgements with the requester's load id and coordinates. Return-path backpressure is absorbed by a small return FIFO, and the request side is credited so that no accepted request is ever dropped. Sits between the endpoint's incoming-request interface and its returning-data interface.

## Interface
- `data_width_p`, 32, word width.
- `addr_width_p`, 32, word address width of incoming requests.
- `x_cord_width_p`, "inv", X coordinate width.
- `y_cord_width_p`, "inv", Y coordinate width.
- `load_id_width_p`, 11, load id width.
- `mem_els_p`, 1024, memory depth in words; power of two, ≥2.
- `ret_fifo_els_p`, 2, return FIFO depth; ≥2.
- `clk_i` input 1: the single clock.
- `reset_n_i` input 1: asynchronous, active-low reset.
- `in_v_i` input 1: request valid.
- `in_yumi_o` output 1: request accepted this cycle.
- `in_we_i` input 1: 1 = store, 0 = load.
- `in_addr_i` input addr_width_p: word address.
- `in_data_i` input data_width_p: store data.
- `in_mask_i` input data_width_p/8: store byte mask.
- `in_load_id_i` input load_id_width_p: requester load id.
- `in_src_x_i` input x_cord_width_p: requester X coordinate.
- `in_src_y_i` input y_cord_width_p: requester Y coordinate.
- `ret_v_o` output 1: return valid.
- `ret_ready_i` input 1: consumer ready.
- `ret_is_load_o` output 1: 1 = load data, 0 = store ack.
- `ret_data_o` output data_width_p: load data; 0 for store acks.
- `ret_load_id_o` output load_id_width_p: echoed load id.
- `ret_x_o` output x_cord_width_p: echoed source X.
- `ret_y_o` output y_cord_width_p: echoed source Y.
- `err_o` output 1: sticky out-of-range flag.

## Operation
**Acceptance**
- `in_yumi_o = in_v_i & (count + s1_v - deq < ret_fifo_els_p)`.
- `count` is the FIFO occupancy, `s1_v` is the pipeline register valid, and `deq = ret_v_o & ret_ready_i`.
- The combinational path from `ret_ready_i` to `in_yumi_o` is intentional.

**Stage 0 (accept cycle)**
- Store: the memory is written at the clock edge. With the mask feature, only masked bytes are written.
- Load: synchronous read.
- Load id, coordinates, `we`, and range status are captured into stage 1.

**Range check**
- A request is out of range when `in_addr_i >= mem_els_p`, compared on the full address width.
- Out-of-range store: memory is not modified.
- Out-of-range load: returns 0.
- Both cases set `err_o`, which stays set until reset.
- Both cases still produce a return, so the requester's credit is restored.

**Stage 1**
- The response is pushed into the return FIFO unconditionally; space is guaranteed by the acceptance rule.

**Return FIFO**
- Head drives the `ret_*` outputs.
- Pops on `deq`.
- Push and pop in the same cycle keeps `count` unchanged.

**Ordering and hazards**
- Returns are produced strictly in acceptance order.
- A store followed by a load to the same address on the next cycle returns the new data.

**Reset**
- Assertion is asynchronous and takes effect mid-operation.
- Clears `s1_v`, FIFO pointers and count, and `err_o`.
- In-flight responses are discarded.
- Memory contents are not reset and are retained.

## Timing
- Reset values: `in_yumi_o` 0 (combinational, 0 while `in_v_i` = 0); `ret_v_o` 0; `ret_*` data fields 0; `err_o` 0.
- Latency: a request accepted at cycle t shows `ret_v_o` = 1 at t+2 if the FIFO was empty.
- Throughput: one request per cycle sustained while `ret_ready_i` = 1.
- With `ret_ready_i` = 0: at most `ret_fifo_els_p` requests are accepted, then `in_yumi_o` = 0 until a pop.
- `ret_*` outputs hold stable while `ret_v_o` = 1 and `ret_ready_i` = 0.
- `err_o` rises in the cycle after the offending request is accepted.

## Configuration
- `BSG_MANYCORE_RESPONDER_BYTE_MASK_EN`
  - Defined: stores write only bytes where `in_mask_i[b]` = 1. A store with mask 0 still returns an ack.
  - Undefined: `in_mask_i` is ignored and every store writes the full word.

## Test plan
1. **Store then load:** store 0xDEADBEEF to addr 5 (id 3, x 2, y 1), then load addr 5 (id 4). Required: ack with `is_load` 0, data 0, id 3, x 2, y 1; then `is_load` 1, data 0xDEADBEEF, id 4; each return 2 cycles after its acceptance.
2. **Backpressure:** hold `ret_ready_i` = 0 and present 4 back-to-back loads. Required: exactly 2 accepted, `in_yumi_o` 0 afterwards. Raise ready: remaining loads are accepted, and all 4 returns arrive in order with correct ids.
3. **Out of range:** load addr `mem_els_p`, store addr `mem_els_p`+7. Required: load returns data 0, store returns an ack, memory unchanged, `err_o` = 1 from the cycle after acceptance until reset.
4. **Byte mask (macro defined):** with addr 9 = 0x11223344, store 0xAABBCCDD with mask 4'b0101, then load addr 9. Required: 0x11BB33DD. Macro undefined: 0xAABBCCDD.
5. **Streaming:** 64 consecutive alternating stores and loads with `ret_ready_i` = 1. Required: `in_yumi_o` = 1 every cycle, 64 in-order returns, data matches the reference model.
6. **Mid-stream reset:** assert `reset_n_i` while 2 returns are pending. Required: `ret_v_o` = 0 immediately. After release, a load of a previously stored address returns the stored value.
